// File: rtl/imem_boot_loader_pkg.sv
// Shared types, constants and checksum helper for the IMEM boot loader.
package imem_boot_loader_pkg;

  localparam int LEN_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W     = 11;
  localparam int DEF_DEPTH      = 2048;

  typedef enum logic [2:0] {
    ST_LEN  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } boot_state_e;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready channel feeding the boot loader.
interface imem_boot_loader_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);

endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words; pulses word_valid
// the cycle after the fourth byte of a word lands.
module imem_boot_loader_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        lane_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_r;
  logic [31:0] word_r;
  logic        word_valid_r;
  logic        lane_last_s;

  assign lane_last_s = (lane_r == 2'(BYTES_PER_WORD - 1));

  // Lane counter, byte insertion and word-complete pulse.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      lane_r       <= 2'd0;
      word_r       <= 32'd0;
      word_valid_r <= 1'b0;
    end else if (clear) begin
      lane_r       <= 2'd0;
      word_r       <= 32'd0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= byte_en && lane_last_s;
      if (byte_en) begin
        word_r[{lane_r, 3'b000} +: 8] <= byte_data;
        lane_r                        <= lane_r + 2'd1;
      end
    end
  end

  assign lane_last  = lane_last_s;
  assign word_valid = word_valid_r;
  assign word       = word_r;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses length/payload/checksum frame, writes IMEM words and holds
// the CPU in reset until a verified image is in place.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk_in,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  input  logic                reload,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_waddr,
  output logic [31:0]         imem_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  boot_state_e       state_r, state_next_s;
  logic [1:0]        len_cnt_r;
  logic [31:0]       len_r;
  logic [7:0]        csum_r;
  logic [ADDR_W:0]   waddr_r;
  logic              byte_ready_r, cpu_hold_r, done_r, error_r;
  logic              byte_ready_s, cpu_hold_s, done_s, error_s;
  logic              xfer_s, reload_go_s, pack_byte_s, lane_last_s, word_valid_s;
  logic [31:0]       n_full_s, word_s;
  logic [ADDR_W:0]   waddr_inc_s;

  assign xfer_s      = bus.byte_valid && byte_ready_r;
  assign reload_go_s = reload && ((state_r == ST_DONE) || (state_r == ST_ERR));
  assign pack_byte_s = xfer_s && (state_r == ST_DATA);
  // Word count is complete once the 4th length byte arrives on the bus.
  assign n_full_s    = {bus.byte_data, len_r[23:0]};
  assign waddr_inc_s = waddr_r + (ADDR_W + 1)'(1);

  imem_boot_loader_byte_packer u_packer (
    .clk_in     (clk_in),
    .reset      (reset),
    .clear      (reload_go_s),
    .byte_en    (pack_byte_s),
    .byte_data  (bus.byte_data),
    .lane_last  (lane_last_s),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // FSM state register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r <= ST_LEN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_LEN: begin
        if (xfer_s && (len_cnt_r == 2'(LEN_BYTES - 1))) begin
          if (n_full_s == 32'd0) begin
            state_next_s = ST_CSUM;
          end else if (n_full_s > 32'(DEPTH)) begin
            state_next_s = ST_ERR;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (pack_byte_s && lane_last_s && (32'(waddr_inc_s) == len_r)) begin
          state_next_s = ST_CSUM;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (xfer_s) begin
          state_next_s = (bus.byte_data == csum_r) ? ST_DONE : ST_ERR;
        end else begin
          state_next_s = ST_CSUM;
        end
      end
      ST_DONE, ST_ERR: begin
        if (reload) begin
          state_next_s = ST_LEN;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ST_LEN;
    endcase
  end

  // FSM output decode, evaluated on the next state so the registered outputs
  // change on the same edge as the state.
  always_comb begin
    byte_ready_s = 1'b0;
    cpu_hold_s   = 1'b1;
    done_s       = 1'b0;
    error_s      = 1'b0;
    case (state_next_s)
      ST_LEN, ST_DATA, ST_CSUM: byte_ready_s = 1'b1;
      ST_DONE: begin
        cpu_hold_s = 1'b0;
        done_s     = 1'b1;
      end
      ST_ERR:  error_s = 1'b1;
      default: byte_ready_s = 1'b0;
    endcase
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      byte_ready_r <= 1'b0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      byte_ready_r <= byte_ready_s;
      cpu_hold_r   <= cpu_hold_s;
      done_r       <= done_s;
      error_r      <= error_s;
    end
  end

  // Length capture, running checksum and IMEM word index.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      len_cnt_r <= 2'd0;
      len_r     <= 32'd0;
      csum_r    <= 8'd0;
      waddr_r   <= '0;
    end else if (reload_go_s) begin
      len_cnt_r <= 2'd0;
      len_r     <= 32'd0;
      csum_r    <= 8'd0;
      waddr_r   <= '0;
    end else begin
      if (xfer_s && (state_r == ST_LEN)) begin
        len_r[{len_cnt_r, 3'b000} +: 8] <= bus.byte_data;
        len_cnt_r                       <= len_cnt_r + 2'd1;
      end
      if (pack_byte_s) begin
        csum_r <= csum_step(csum_r, bus.byte_data);
      end
      // Index advances after the write cycle so imem_waddr is valid during it.
      if (word_valid_s) begin
        waddr_r <= waddr_inc_s;
      end
    end
  end

  assign bus.byte_ready = byte_ready_r;
  assign imem_we        = word_valid_s;
  assign imem_waddr     = waddr_r[ADDR_W-1:0];
  assign imem_wdata     = word_s;
  assign cpu_hold       = cpu_hold_r;
  assign done           = done_r;
  assign error          = error_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected IMEM writes are queued as bytes
// are driven and checked as write strobes appear.
module tb_imem_boot_loader;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              clk_in = 1'b0;
  logic              reset  = 1'b1;
  logic              reload = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold, done, error;

  imem_boot_loader_if bus();

  imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .bus        (bus),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t         sb_q[$];
  logic [31:0] img_w [0:15];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk_in) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_we", 32'(imem_we), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("waddr", 32'(imem_waddr), 32'(e.a));
        check("wdata", imem_wdata, e.d);
      end
    end
  end

  function automatic logic [7:0] img_csum(input int nw);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < nw; k++) begin
      c = c ^ img_w[k][7:0] ^ img_w[k][15:8] ^ img_w[k][23:16] ^ img_w[k][31:24];
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int n;
    n = 0;
    while (($urandom_range(0, 99) < gap_pct) && (n < 8)) begin
      @(negedge clk_in);
      n++;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    n = 0;
    while ((bus.byte_ready !== 1'b1) && (n < 50)) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(bus.byte_ready), 32'd1);
    @(negedge clk_in);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_image(input logic [31:0] n, input int nw, input logic [7:0] cs,
                            input int gap, input bit skip_first, input bit send_cs);
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      if (!(skip_first && (i == 0))) send_byte(n[8*i +: 8], gap);
    end
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 3) begin
          e.a = ADDR_W'(k);
          e.d = img_w[k];
          sb_q.push_back(e);
        end
        send_byte(img_w[k][8*j +: 8], gap);
      end
    end
    if (send_cs) send_byte(cs, gap);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk_in);
    reload = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h,
                              input logic r);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(h));
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'(r));
    check({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #2 reset = 1'b0;
    #1;
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk_in);
    reset = 1'b1;
    #1 check("ready_first_cycle", 32'(bus.byte_ready), 32'd0);
    @(negedge clk_in);
    check("ready_after_rst", 32'(bus.byte_ready), 32'd1);

    // Good two-word image.
    img_w[0] = 32'h2008_0005;
    img_w[1] = 32'h0000_0000;
    send_image(32'd2, 2, 8'h2D, 0, 1'b0, 1'b1);
    check_status("img_ok", 1'b1, 1'b0, 1'b0, 1'b0);

    // Same image with a wrong checksum.
    pulse_reload();
    send_image(32'd2, 2, 8'h2C, 0, 1'b0, 1'b1);
    check_status("img_badcs", 1'b0, 1'b1, 1'b1, 1'b0);

    // Empty image.
    pulse_reload();
    send_image(32'd0, 0, 8'h00, 0, 1'b0, 1'b1);
    check_status("img_empty", 1'b1, 1'b0, 1'b0, 1'b0);

    // Oversized length: error straight after the length field.
    pulse_reload();
    send_image(32'(DEPTH + 1), 0, 8'h00, 0, 1'b0, 1'b0);
    check_status("img_toolong", 1'b0, 1'b1, 1'b1, 1'b0);

    // Largest legal-sized check would be long; 16 random words, gap-free then gappy.
    for (int k = 0; k < 16; k++) img_w[k] = $urandom;
    pulse_reload();
    send_image(32'd16, 16, img_csum(16), 0, 1'b0, 1'b1);
    check_status("img16_nogap", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_reload();
    send_image(32'd16, 16, img_csum(16), 30, 1'b0, 1'b1);
    check_status("img16_gap", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the payload, then a full resend.
    img_w[0] = 32'h2008_0005;
    img_w[1] = 32'h0000_0000;
    pulse_reload();
    send_image(32'd2, 1, 8'h00, 0, 1'b0, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b0;
    #1;
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_ready", 32'(bus.byte_ready), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    send_image(32'd2, 2, 8'h2D, 0, 1'b0, 1'b1);
    check_status("img_resend", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reach ERR, then reload together with a byte: byte refused, taken next cycle.
    pulse_reload();
    send_image(32'd2, 2, 8'h2C, 0, 1'b0, 1'b1);
    check("err_state", 32'(error), 32'd1);
    img_w[0] = 32'hDEAD_BEEF;
    reload         = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h01;
    #1 check("reload_refuse", 32'(bus.byte_ready), 32'd0);
    @(negedge clk_in);
    reload = 1'b0;
    check("reload_ready", 32'(bus.byte_ready), 32'd1);
    @(negedge clk_in);
    bus.byte_valid = 1'b0;
    send_image(32'd1, 1, img_csum(1), 0, 1'b1, 1'b1);
    check_status("img_after_reload", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
